// File: rtl/disp_sched.sv
// disp_sched -- two-requester scheduler feeding a hex display word.
//
// A requester offering a word is granted for one ACCEPT cycle. If its valid
// is still high in that cycle, the word is transferred to o_data and held on
// screen for HOLD_TICKS i_tick strobes. If the valid has dropped, the grant is
// abandoned and nothing is transferred. The display is never blanked except
// by reset.
//
// Compile-time option: DISP_SCHED_RR_EN
//   defined   -> round-robin arbitration between the two requesters
//   undefined -> fixed priority, requester 0 first
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_tick                one-cycle timebase strobe
//   i_reqN_valid/_data    requester N offers a word (held until ready)
//   o_reqN_ready          one-cycle accept strobe to requester N
//   o_data, o_owner       displayed word and the requester it came from
//   o_busy                high whenever the scheduler is not idle
module disp_sched #(
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_owner,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        HOLD   = 2'd2
    } state_t;

`ifdef DISP_SCHED_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_CNT = 8'(HOLD_TICKS - 1);

    state_t              state_q;
    logic                winner_q;
    logic                last_grant_q;
    logic [7:0]          cnt_q;
    logic                winner_d;
    logic                win_valid;
    logic [DATA_W-1:0]   win_data;

    // Contention only matters when both offer; otherwise the lone valid wins.
    always_comb begin
        winner_d = ~i_req0_valid;
        if (RR_EN && i_req0_valid && i_req1_valid) begin
            winner_d = ~last_grant_q;
        end
    end

    always_comb begin
        win_valid = winner_q ? i_req1_valid : i_req0_valid;
        win_data  = winner_q ? i_req1_data  : i_req0_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            o_data       <= '0;
            o_owner      <= 1'b0;
            o_busy       <= 1'b0;
            o_req0_ready <= 1'b0;
            o_req1_ready <= 1'b0;
        end else begin
            o_req0_ready <= 1'b0;
            o_req1_ready <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_req0_valid || i_req1_valid) begin
                        winner_q     <= winner_d;
                        o_req0_ready <= ~winner_d;
                        o_req1_ready <= winner_d;
                        o_busy       <= 1'b1;
                        state_q      <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (win_valid) begin
                        o_data       <= win_data;
                        o_owner      <= winner_q;
                        last_grant_q <= winner_q;
                        cnt_q        <= '0;
                        state_q      <= HOLD;
                    end else begin
                        o_busy  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (i_tick) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST_CNT) begin
                            o_busy  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the scheduler.
module tb_disp_sched;

    localparam int unsigned HOLD = 3;
`ifdef DISP_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, i_tick, v0, v1;
    logic [15:0] d0, d1;
    logic        o_req0_ready, o_req1_ready, o_owner, o_busy;
    logic [15:0] o_data;

    int vectors = 0;
    int errors  = 0;

    // Model: pending grant index (-1 none) and remaining ticks of the hold.
    logic [15:0] m_data;
    bit          m_owner;
    int          m_last, m_pend, m_left;

    disp_sched #(.HOLD_TICKS(HOLD), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(o_req0_ready),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(o_req1_ready),
        .o_data(o_data), .o_owner(o_owner), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic int arb(bit a, bit b, int last);
        if (RR && a && b) return 1 - last;
        return a ? 0 : 1;
    endfunction

    function automatic logic [19:0] expv();
        return {m_data, m_owner, (m_pend >= 0 || m_left > 0), m_pend == 0, m_pend == 1};
    endfunction

    function automatic logic [19:0] actv();
        return {o_data, o_owner, o_busy, o_req0_ready, o_req1_ready};
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic cycle();
        bit r = rst_n, t = i_tick, a = v0, b = v1;
        logic [15:0] x = d0, y = d1;
        @(posedge clk);
        if (!r) begin
            m_data = '0; m_owner = 0; m_last = 1; m_pend = -1; m_left = 0;
        end else if (m_pend >= 0) begin
            if ((m_pend == 1) ? b : a) begin
                m_data = (m_pend == 1) ? y : x;
                m_owner = (m_pend == 1);
                m_last = m_pend;
                m_left = HOLD;
            end
            m_pend = -1;
        end else if (m_left > 0) begin
            if (t) m_left--;
        end else if (a || b) begin
            m_pend = arb(a, b, m_last);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; i_tick = 1; v0 = 1; v1 = 1; d0 = 16'h1234; d1 = 16'h5678;
        for (int k = 0; k < 3; k++) begin
            cycle();
            vectors++;
            if (actv() !== 20'h0) begin
                errors++; $display("FAIL reset_hold got %h want %h", actv(), 20'h0);
            end
        end
        v0 = 0; v1 = 0; rst_n = 1;
        for (int k = 0; k < 10; k++) begin
            i_tick = ($urandom % 2) != 0;
            cycle();
            vectors++;
            if (actv() !== expv() || o_data !== 16'h0000 || o_busy !== 1'b0 ||
                o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin
                errors++; $display("FAIL reset_idle got %h want %h", actv(), expv());
            end
        end
        i_tick = 0;
    endtask

    task automatic test_single();
        int ticks = 0;
        v0 = 1; d0 = 16'hBEEF;
        cycle();
        vectors++;
        if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0 || actv() !== expv()) begin
            errors++; $display("FAIL single_ready got %h want %h", actv(), expv());
        end
        cycle();
        v0 = 0;
        vectors++;
        if (o_data !== 16'hBEEF || o_owner !== 1'b0 || o_req0_ready !== 1'b0 ||
            actv() !== expv()) begin
            errors++; $display("FAIL single_data got %h want %h", actv(), expv());
        end
        for (int k = 0; k < 40 && ticks < HOLD; k++) begin
            i_tick = (k % 4) == 3;
            if (i_tick) ticks++;
            cycle();
            vectors++;
            if (actv() !== expv() || o_busy !== (ticks < HOLD)) begin
                errors++; $display("FAIL single_hold got %h want %h", actv(), expv());
            end
        end
        i_tick = 0;
        vectors++;
        if (ticks != HOLD) begin
            errors++; $display("FAIL single_timeout got %0d ticks want %0d", ticks, HOLD);
        end
    endtask

    task automatic test_both();
        int grants[$];
        int prev = -1;
        rst_n = 0; cycle(); rst_n = 1;
        v0 = 1; v1 = 1; d0 = 16'h1111; d1 = 16'h2222;
        for (int k = 0; k < 300 && grants.size() < 4; k++) begin
            i_tick = (k % 3) == 0;
            cycle();
            vectors++;
            if (actv() !== expv()) begin
                errors++; $display("FAIL both_cycle got %h want %h", actv(), expv());
            end
            if (prev >= 0) begin
                vectors++;
                if (o_data !== ((prev == 1) ? 16'h2222 : 16'h1111)) begin
                    errors++; $display("FAIL both_word got %h want grant %0d word", o_data, prev);
                end
            end
            prev = -1;
            if (o_req0_ready) begin grants.push_back(0); prev = 0; end
            if (o_req1_ready) begin grants.push_back(1); prev = 1; end
        end
        v0 = 0; v1 = 0; i_tick = 0;
        vectors++;
        if (grants.size() != 4) begin
            errors++; $display("FAIL both_timeout got %0d grants want 4", grants.size());
        end
        foreach (grants[i]) begin
            vectors++;
            if (grants[i] != (RR ? (i % 2) : 0)) begin
                errors++; $display("FAIL both_order idx %0d got %0d want %0d", i, grants[i], RR ? (i % 2) : 0);
            end
        end
    endtask

    task automatic test_abort();
        bool_wait: begin end
        rst_n = 0; cycle(); rst_n = 1;
        v0 = 1; d0 = 16'hAAAA;
        cycle(); cycle(); v0 = 0;
        i_tick = 1;
        for (int k = 0; k < 10 && o_busy; k++) cycle();
        i_tick = 0;
        vectors++;
        if (o_busy !== 1'b0 || o_data !== 16'hAAAA || actv() !== expv()) begin
            errors++; $display("FAIL abort_setup got %h want %h", actv(), expv());
        end
        v1 = 1; d1 = 16'h3333;
        cycle();
        vectors++;
        if (o_req1_ready !== 1'b1 || actv() !== expv()) begin
            errors++; $display("FAIL abort_grant got %h want %h", actv(), expv());
        end
        v1 = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            vectors++;
            if (o_data !== 16'hAAAA || o_owner !== 1'b0 || o_busy !== 1'b0 ||
                o_req1_ready !== 1'b0 || actv() !== expv()) begin
                errors++; $display("FAIL abort_idle got %h want %h", actv(), expv());
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int ticks = 0;
        rst_n = 0; cycle(); rst_n = 1;
        v0 = 1; d0 = 16'h5A5A;
        cycle(); cycle(); v0 = 0;
        i_tick = 1; cycle(); i_tick = 0;
        vectors++;
        if (o_busy !== 1'b1 || o_data !== 16'h5A5A || actv() !== expv()) begin
            errors++; $display("FAIL midhold_pre got %h want %h", actv(), expv());
        end
        rst_n = 0; cycle(); rst_n = 1;
        vectors++;
        if (o_data !== 16'h0000 || o_busy !== 1'b0 || actv() !== expv()) begin
            errors++; $display("FAIL midhold_reset got %h want %h", actv(), expv());
        end
        v0 = 1; d0 = 16'hC3C3;
        cycle(); cycle(); v0 = 0;
        vectors++;
        if (o_data !== 16'hC3C3 || actv() !== expv()) begin
            errors++; $display("FAIL midhold_serve got %h want %h", actv(), expv());
        end
        i_tick = 1;
        for (int k = 0; k < 10 && o_busy; k++) begin
            cycle(); ticks++;
        end
        i_tick = 0;
        vectors++;
        if (ticks != HOLD || o_busy !== 1'b0) begin
            errors++; $display("FAIL midhold_hold got %0d ticks want %0d", ticks, HOLD);
        end
    endtask

    task automatic test_random();
        bit done0 = 0, done1 = 0;
        rst_n = 0; cycle(); rst_n = 1;
        for (int k = 0; k < 3000; k++) begin
            rst_n  = ($urandom % 300) != 0;
            i_tick = ($urandom % 3) == 0;
            cycle();
            vectors++;
            if (actv() !== expv()) begin
                errors++; $display("FAIL random_cyc%0d got %h want %h", k, actv(), expv());
            end
            // Requesters: hold until ready, occasionally withdraw during ACCEPT.
            if (o_req0_ready) begin
                if ($urandom % 8 == 0) v0 = 0; else done0 = 1;
            end else if (done0) begin
                v0 = 0; done0 = 0;
            end else if (!v0 && $urandom % 4 == 0) begin
                v0 = 1; d0 = 16'($urandom);
            end
            if (o_req1_ready) begin
                if ($urandom % 8 == 0) v1 = 0; else done1 = 1;
            end else if (done1) begin
                v1 = 0; done1 = 0;
            end else if (!v1 && $urandom % 4 == 0) begin
                v1 = 1; d1 = 16'($urandom);
            end
        end
        v0 = 0; v1 = 0; i_tick = 0;
    endtask

    initial begin
        m_data = '0; m_owner = 0; m_last = 1; m_pend = -1; m_left = 0;
        rst_n = 0; i_tick = 0; v0 = 0; v1 = 0; d0 = '0; d1 = '0;
        #1;
        test_reset();
        test_single();
        test_both();
        test_abort();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter HOLD_TICKS, default 3, number of i_tick strobes the granted value remains displayed; legal range 1..255.
REQ-002 Parameter DATA_W, default 16, display word width (four hex digits).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_tick  input  1  one-cycle timebase strobe, e.g. clkdiv output.
REQ-006 i_req0_valid  input  1  requester 0 offers a word.
REQ-007 i_req0_data  input  DATA_W  requester 0 word.
REQ-008 o_req0_ready  output  1  one-cycle accept strobe to requester 0.
REQ-009 i_req1_valid, i_req1_data, o_req1_ready  as REQ-006..008, for requester 1.
REQ-010 o_data  output  DATA_W  word to the hex display datapath.
REQ-011 o_owner  output  1  index of the requester whose word is on o_data.
REQ-012 o_busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, ACCEPT, HOLD; all outputs registered.
REQ-014 IDLE: if any valid is high, latch the winner and go to ACCEPT the next cycle; otherwise stay in IDLE.
REQ-015 ACCEPT lasts exactly one cycle; o_reqN_ready is high for the winner only, and both readies are low in every other state.
REQ-016 Transfer occurs when ready and valid are both high in ACCEPT: o_data <= winner data, o_owner <= winner, last_grant <= winner, counter <= 0, next state HOLD.
REQ-017 Winner valid low in ACCEPT: abort, no transfer, o_data/o_owner/last_grant unchanged, next state IDLE.
REQ-018 Latency: valid first seen high in IDLE at cycle N -> ready at N+1 -> o_data updated at N+2.
REQ-019 Requesters hold valid and data stable until ready; data is sampled only in the ACCEPT cycle.
REQ-020 HOLD: each i_tick increments an 8-bit counter; an i_tick with counter == HOLD_TICKS-1 moves the FSM to IDLE.
REQ-021 i_tick in IDLE or ACCEPT is ignored; the counter never wraps.
REQ-022 o_data holds the last transferred word through IDLE and through aborts; the display is never blanked.
REQ-023 Arbitration per REQ-034/035; a single valid requester always wins.

Reset
REQ-024 rst_n low at a posedge: state IDLE, o_data 0, o_owner 0, o_busy 0, both readies 0, counter 0, last_grant 1.
REQ-025 Reset mid-ACCEPT suppresses the transfer; reset mid-HOLD returns to IDLE on the next cycle with o_data cleared.
REQ-026 i_tick and valids are ignored while rst_n is low.

Configuration
REQ-027 Macro DISP_SCHED_RR_EN selects the arbitration policy.
REQ-034 Macro defined: round robin; with both valids high in IDLE, the requester != last_grant wins; after reset requester 0 wins first.
REQ-035 Macro undefined: fixed priority; requester 0 wins whenever i_req0_valid is high; last_grant is still updated but unused.

Verification
REQ-028 Reset, HOLD_TICKS=3, no requests -> o_data=0000, o_busy=0, readies never asserted.
REQ-029 req0 valid data=16'hBEEF at cycle 10 -> o_req0_ready=1 at cycle 11 only, o_data=BEEF and o_owner=0 at cycle 12, o_busy drops 1 cycle after the 3rd i_tick.
REQ-030 Both valid continuously (0:1111, 1:2222), RR_EN defined -> grants alternate 0,1,0,1, and o_data alternates 1111/2222 every 3 ticks.
REQ-031 Same stimulus, RR_EN undefined -> only requester 0 is granted, and o_req1_ready is never high.
REQ-032 req1 drops valid in its ACCEPT cycle -> no transfer, o_data unchanged, FSM returns to IDLE, and o_busy=0 the cycle after.
REQ-033 rst_n pulsed low during HOLD after 1 tick -> next cycle o_data=0000 and IDLE; a new request is served with the full 3-tick hold.
